// File: rtl/mnist_pkg.sv
// Shared constants and FSM state type for the MNIST result UART reporter.
package mnist_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Results above 9 are not digits; report them as '?'.
  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return (d <= 4'd9) ? (ASCII_ZERO + {4'h0, d}) : ASCII_QMARK;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer, LSB first; a byte accepted on valid&ready drives its start bit the next cycle.
// ready is high in IDLE and in the final stop-bit cycle, so a byte offered then follows with no gap.
module uart_tx_byte
  import mnist_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    ready     = 1'b0;
    tx        = 1'b1;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          state_n = ST_START;
          shreg_n = data;
          cnt_n   = '0;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_end) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = ST_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_DATA: begin
        tx = shreg[bit_idx];
        if (bit_end) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) state_n = ST_STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          ready = 1'b1;
          cnt_n = '0;
          if (valid) begin
            state_n = ST_START;
            shreg_n = data;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mnist_result_uart.sv
// Sends "<digit> CR LF" over UART on each rising edge of done; start bit one cycle after the edge.
// Results arriving mid-message are dropped and latched in the sticky overrun flag.
module mnist_result_uart
  import mnist_pkg::*;
#(
  parameter int CLK_HZ       = 25_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done,
  input  logic [3:0] digit,
  output logic       tx,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] msg_count
);

  logic       done_q;
  logic       done_rise;
  logic [1:0] byte_idx;
  logic       ser_valid;
  logic       ser_ready;
  logic [7:0] ser_data;

  assign done_rise = done & ~done_q;

  // Next byte is offered in the cycle the serializer's stop bit ends, keeping frames gapless.
  always_comb begin
    ser_valid = 1'b0;
    ser_data  = ASCII_CR;
    if (!busy) begin
      ser_valid = done_rise;
      ser_data  = ascii_digit(digit);
    end else if (ser_ready && (byte_idx < 2'd2)) begin
      ser_valid = 1'b1;
      ser_data  = (byte_idx == 2'd0) ? ASCII_CR : ASCII_LF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q    <= 1'b0;
      busy      <= 1'b0;
      byte_idx  <= '0;
      overrun   <= 1'b0;
      msg_count <= '0;
    end else begin
      done_q <= done;
      if (!busy) begin
        if (done_rise) begin
          busy     <= 1'b1;
          byte_idx <= '0;
        end
      end else begin
        if (done_rise) overrun <= 1'b1;
        if (ser_ready) begin
          if (byte_idx < 2'd2) begin
            byte_idx <= byte_idx + 2'd1;
          end else begin
            busy      <= 1'b0;
            msg_count <= msg_count + 8'd1;
          end
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (ser_data),
    .valid(ser_valid),
    .ready(ser_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_mnist_result_uart.sv
// Directed bench for mnist_result_uart with a mid-bit serial monitor on tx.
module tb_mnist_result_uart;

  localparam int CPB     = 4;
  localparam int MSG_CYC = 30 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       tx;
  logic       busy;
  logic       overrun;
  logic [7:0] msg_count;

  mnist_result_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .digit    (digit),
    .tx       (tx),
    .busy     (busy),
    .overrun  (overrun),
    .msg_count(msg_count)
  );

  always #5 clk = ~clk;

  // Serial monitor: detects a start bit, then samples each bit at offset CPB/2.
  logic [7:0] rx_mem [0:4095];
  int         rx_wr = 0;
  int         frame_err = 0;
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB/2 && tx !== 1'b0) frame_err++;
      if (mon_cnt >= CPB/2 + CPB && mon_cnt < CPB/2 + 9*CPB && ((mon_cnt - CPB/2) % CPB) == 0)
        mon_byte[3'((mon_cnt - CPB/2) / CPB - 1)] = tx;
      if (mon_cnt == CPB/2 + 9*CPB) begin
        if (tx !== 1'b1) frame_err++;
        rx_mem[rx_wr[11:0]] = mon_byte;
        rx_wr++;
        mon_active = 1'b0;
      end
    end
  end

  typedef struct {
    logic [3:0] digit;
    int         hold;
    logic [7:0] exp_char;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs [5];
  int   checks = 0;
  int   errors = 0;
  int   rx_rd = 0;
  int   bcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_msg(input string tag, input logic [7:0] ch);
    int avail;
    avail = rx_wr - rx_rd;
    check({tag, "_bytes"}, 32'(avail), 32'd3);
    if (avail >= 3) begin
      check({tag, "_b0"}, 32'(rx_mem[rx_rd[11:0]]), 32'(ch));
      check({tag, "_b1"}, 32'(rx_mem[12'(rx_rd + 1)]), 32'h0D);
      check({tag, "_b2"}, 32'(rx_mem[12'(rx_rd + 2)]), 32'h0A);
    end
    rx_rd = rx_wr;
  endtask

  // Raise done with digit d, hold it for 'hold' cycles, scramble digit after capture, count busy cycles.
  task automatic run_msg(input logic [3:0] d, input int hold, input int total, output int nbusy);
    @(negedge clk);
    digit = d;
    done  = 1'b1;
    nbusy = 0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      if (c == hold - 1) done = 1'b0;
      if (c == 5) digit = ~d;
      if (busy) nbusy++;
    end
    done = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'd6,  1,   8'h36, 8'd1};
    vecs[1] = '{4'd9,  500, 8'h39, 8'd2};
    vecs[2] = '{4'd12, 1,   8'h3F, 8'd3};
    vecs[3] = '{4'd15, 3,   8'h3F, 8'd4};
    vecs[4] = '{4'd0,  2,   8'h30, 8'd5};

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_count", 32'(msg_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_msg(vecs[i].digit, vecs[i].hold, (vecs[i].hold > 150) ? vecs[i].hold + 20 : 150, bcnt);
      check("vec_busy_cycles", 32'(bcnt), 32'(MSG_CYC));
      expect_msg("vec", vecs[i].exp_char);
      check("vec_count", 32'(msg_count), 32'(vecs[i].exp_count));
      check("vec_overrun", 32'(overrun), 32'd0);
    end

    // Second result 50 cycles into a message must be dropped.
    do_reset();
    @(negedge clk);
    digit = 4'd3;
    done  = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) done = 1'b0;
      if (c == 48) begin
        digit = 4'd2;
        done  = 1'b1;
      end
      if (c == 49) done = 1'b0;
    end
    expect_msg("ovr", 8'h33);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_count", 32'(msg_count), 32'd1);

    // Reset during the CR byte's data bits.
    do_reset();
    check("ovr_cleared", 32'(overrun), 32'd0);
    @(negedge clk);
    digit = 4'd7;
    done  = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_start", 32'(tx), 32'd0);
    repeat (54) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(msg_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_partial", 32'(rx_wr - rx_rd), 32'd1);
    if (rx_wr > rx_rd) check("midrst_first", 32'(rx_mem[rx_rd[11:0]]), 32'h37);
    rx_rd = rx_wr;
    run_msg(4'd0, 1, 150, bcnt);
    expect_msg("after_rst", 8'h30);
    check("after_rst_count", 32'(msg_count), 32'd1);

    // done held high through reset produces one message once reset drops.
    @(negedge clk);
    rst   = 1'b1;
    done  = 1'b1;
    digit = 4'd4;
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    bcnt = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    done = 1'b0;
    check("rstdone_busy_cycles", 32'(bcnt), 32'(MSG_CYC));
    expect_msg("rstdone", 8'h34);
    check("rstdone_count", 32'(msg_count), 32'd1);

    // 256 back-to-back messages: counter wraps, every byte clean.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      digit = 4'(i % 10);
      done  = 1'b1;
      @(negedge clk);
      done = 1'b0;
      wait_idle(300);
      expect_msg("wrap", 8'h30 + 8'(i % 10));
      if (i == 254) check("wrap_count_255", 32'(msg_count), 32'd255);
    end
    check("wrap_count_0", 32'(msg_count), 32'd0);
    check("wrap_overrun", 32'(overrun), 32'd0);
    repeat (10) @(negedge clk);
    check("wrap_no_extra", 32'(rx_wr - rx_rd), 32'd0);
    check("frame_errors", 32'(frame_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
